// File: rtl/riscv_pkg.sv
// Shared constants and types for the front end of the core.
package riscv_pkg;

    localparam int unsigned RV_XLEN    = 32;
    localparam int unsigned INSTR_SIZE = 32;
    localparam logic [31:0] NOP_FETCH  = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && (count_q != CW'(DEPTH)) && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, small instruction buffer,
// redirect flush with a one-cycle chng2nop pulse to the control unit.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN       = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            pc_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    output logic            chng2nop
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            chng2nop_q, chng2nop_d;
    logic            req_c, issue, push, pop, outstanding;
    logic [CW-1:0]   count;
    logic [2*XLEN-1:0] head_data;

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({imem_rdata, req_pc_q}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_data),
        .count     (count)
    );

    // Issue only with buffer credit, so a returning word always has a slot.
    always_comb begin
        outstanding = (state_q != IDLE);
        req_c       = !rst && (state_q == IDLE) && !redirect_valid
                      && ((count + CW'(outstanding)) < CW'(FIFO_DEPTH));
        issue       = req_c && imem_ack;
        push        = (state_q == WAIT) && imem_rvalid && !redirect_valid;
        pop         = (count != '0) && !stall && pc_en;

        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        chng2nop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (issue) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) state_d = IDLE;
            end
            DRAIN: begin
                if (imem_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A response landing in the redirect cycle is consumed here, so nothing is left to drain.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            chng2nop_d = 1'b1;
            state_d    = (issue || (outstanding && !imem_rvalid)) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            chng2nop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            chng2nop_q <= chng2nop_d;
        end
    end

    assign imem_req    = req_c;
    assign imem_addr   = fetch_pc_q & ~XLEN'(3);
    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? head_data[2*XLEN-1:XLEN] : XLEN'(NOP_FETCH);
    assign pc_out      = instr_valid ? head_data[XLEN-1:0] : '0;
    assign chng2nop    = chng2nop_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural imem with configurable latency feeds
// an expected-instruction queue that is compared against the head every cycle.
module tb_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst, stall, pc_en, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req, imem_ack, imem_rvalid;
    logic [XLEN-1:0] imem_addr, imem_rdata;
    logic [XLEN-1:0] instr_out, pc_out;
    logic            instr_valid, chng2nop;

    fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .chng2nop       (chng2nop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
        logic [31:0] ready;
    } mreq_t;

    entry_t      exp_q [$];
    mreq_t       mem_q [$];
    int unsigned cyc;
    int unsigned mem_lat;
    logic        ack_en;
    logic        const_mem;
    logic [31:0] exp_fetch;
    logic        exp_chng;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return const_mem ? 32'h0000_0013 : ((a ^ 32'hA5A5_0000) | 32'h3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive memory, compare head against the model, then advance the model.
    task automatic step();
        mreq_t  m;
        entry_t e;
        logic   pop_ok;
        @(negedge clk);
        if (!rst && mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        imem_ack = imem_req & ack_en;
        #1;
        check_eq("chng2nop", 32'(chng2nop), 32'(exp_chng));
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_eq("head_pc", pc_out, exp_q[0].pc);
            check_eq("head_instr", instr_out, exp_q[0].instr);
        end else begin
            check_eq("empty_pc", pc_out, 32'h0);
            check_eq("empty_instr", instr_out, 32'h0);
        end
        if (rst) begin
            check_eq("req_in_rst", 32'(imem_req), 32'h0);
            mem_q.delete();
            exp_q.delete();
            exp_fetch = RST_PC;
            exp_chng  = 1'b0;
        end else begin
            if (imem_req) begin
                check_eq("imem_addr", imem_addr, exp_fetch);
                check_eq("single_outstanding", 32'(mem_q.size()), 32'h0);
            end
            pop_ok = (exp_q.size() != 0) && !stall && pc_en && !redirect_valid;
            if (pop_ok) void'(exp_q.pop_front());
            if (imem_rvalid) begin
                m = mem_q.pop_front();
                if (!m.stale && !redirect_valid) begin
                    e.pc    = m.addr;
                    e.instr = mem_word(m.addr);
                    exp_q.push_back(e);
                end
            end
            if (imem_req && imem_ack) begin
                m.addr  = imem_addr;
                m.stale = 1'b0;
                m.ready = cyc + mem_lat;
                mem_q.push_back(m);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (redirect_valid) begin
                for (int i = 0; i < mem_q.size(); i++) begin
                    m       = mem_q[i];
                    m.stale = 1'b1;
                    mem_q[i] = m;
                end
                exp_q.delete();
                exp_fetch = redirect_pc & ~32'h3;
            end
            exp_chng = redirect_valid;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = instr_valid;
        end
        check_eq(tag, 32'(seen), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        n_checks = 0; n_fail = 0; cyc = 0;
        rst = 1'b1; stall = 1'b0; pc_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mem_lat = 1; ack_en = 1'b1; const_mem = 1'b1; exp_fetch = RST_PC; exp_chng = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then zero-wait memory returning 0x13 everywhere.
        step();
        check_eq("rst_addr", imem_addr, RST_PC);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        rst = 1'b0;
        step();
        check_eq("lat_c1_valid", 32'(instr_valid), 32'h0);
        step();
        check_eq("lat_c2_valid", 32'(instr_valid), 32'h1);
        check_eq("lat_c2_pc", pc_out, 32'h0);
        check_eq("lat_c2_instr", instr_out, 32'h13);
        repeat (10) step();

        // Stall from reset: buffer fills to DEPTH, then requests stop.
        const_mem = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        stall = 1'b1;
        repeat (5) step();
        check_eq("stall_buffered", 32'(exp_q.size()), 32'(DEPTH));
        check_eq("stall_no_req", 32'(imem_req), 32'h0);
        check_eq("stall_head_pc", pc_out, RST_PC);
        stall = 1'b0;
        repeat (8) step();

        // Redirect while a 3-cycle response is outstanding.
        mem_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (mem_q.size() != 0) && (mem_q[0].ready > cyc);
        end
        check_eq("wait_state_reached", 32'(found), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        check_eq("redir_pulse", 32'(chng2nop), 32'h1);
        check_eq("redir_flushed", 32'(instr_valid), 32'h0);
        step();
        check_eq("redir_pulse_end", 32'(chng2nop), 32'h0);
        wait_valid("redir_refill", 30);
        check_eq("redir_first_pc", pc_out, 32'h0000_0100);
        repeat (6) step();

        // Redirect in the same cycle as the response.
        mem_lat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (mem_q.size() != 0) && (mem_q[0].ready == cyc) && !mem_q[0].stale;
        end
        check_eq("rvalid_next_reached", 32'(found), 32'h1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        check_eq("same_cyc_rvalid_seen", 32'(imem_rvalid), 32'h1);
        check_eq("same_cyc_empty", 32'(instr_valid), 32'h0);
        check_eq("same_cyc_instr0", instr_out, 32'h0);
        wait_valid("same_cyc_refill", 10);
        check_eq("same_cyc_first_pc", pc_out, 32'h0000_0200);

        // Slow memory, random consume and ack back-pressure; then redirects back to back.
        mem_lat = 3;
        for (int i = 0; i < 80; i++) begin
            pc_en  = 1'($urandom_range(0, 1));
            ack_en = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 5) == 0);
            step();
        end
        pc_en = 1'b1; ack_en = 1'b1; stall = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; step();
        redirect_pc = 32'h0000_0802; step();
        redirect_valid = 1'b0;
        check_eq("b2b_pulse", 32'(chng2nop), 32'h1);
        wait_valid("b2b_refill", 30);
        check_eq("b2b_first_pc", pc_out, 32'h0000_0800);
        repeat (20) step();

        // Reset while a response is outstanding and one word buffered.
        pc_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            found = (exp_q.size() == 1) && (mem_q.size() == 1);
        end
        check_eq("busy_state_reached", 32'(found), 32'h1);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
        step();
        rst = 1'b0; redirect_valid = 1'b0; pc_en = 1'b1;
        check_eq("midrst_valid", 32'(instr_valid), 32'h0);
        check_eq("midrst_addr", imem_addr, RST_PC);
        check_eq("midrst_chng", 32'(chng2nop), 32'h0);
        wait_valid("midrst_refill", 20);
        check_eq("midrst_first_pc", pc_out, RST_PC);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
